load_store_unit: RTL and testbench

Memory-access initiator between the CPU execute stage and `data_memory`. It accepts one load or store request at a time, drives the word-organised data memory port, and performs sign/zero extension for sub-word loads. It implements byte and halfword stores as read-modify-write sequences. It returns exactly one response per accepted request, including an error response for misaligned or illegal accesses.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the CPU request/response handshake and the word-organised data
//   memory port of the load/store unit.
//   Ports (signals):
//     req_valid/req_ready      request handshake
//     req_wEn, req_funct3      store flag and RISC-V width code
//     req_addr, req_wdata      byte address and store data
//     resp_valid/rdata/error   one-cycle response
//     mem_wEn, mem_address     memory write enable and word-aligned byte address
//     mem_write_data           full word written to memory
//     mem_read_data            registered memory read data
//   Modports: slave = the load/store unit, master = the CPU/memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wEn;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_wEn;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_wEn, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_wEn, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_wEn, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_wEn, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Accepts one load or store at a time from the execute stage, drives the
//   word-organised data memory, extends sub-word load data and performs
//   byte/halfword stores as read-modify-write. Every accepted request gets
//   exactly one response; misaligned or illegal requests answer with an
//   error and never touch memory.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - load_store_unit_if.slave (request, response and memory port)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a request; error check happens on acceptance
//   READ  | memory address presented for the read of the target word
//   DATA  | read word arrives: extend for loads, merge for SB/SH
//   WRITE | single-cycle memory write (SW data or merged word)
//   DONE  | one-cycle response pulse
module load_store_unit (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_error;
  logic        req_is_sw;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Upper address bits are outside the 16-bit memory space.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:16];

  assign accept = bus.req_valid && (state == IDLE);

  // Request decode, evaluated on the live request at acceptance.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
      3'b100, 3'b101:         req_illegal = bus.req_wEn;
      default:                req_illegal = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'b01:   req_misaligned = bus.req_addr[0];
      2'b10:   req_misaligned = (bus.req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_error = req_illegal || req_misaligned;
  assign req_is_sw = bus.req_wEn && (bus.req_funct3[1:0] == 2'b10);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_error) begin
            state_next = DONE;
          end else if (req_is_sw) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:    state_next = DATA;
      DATA:    state_next = wen_q ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; driven purely from state so reset drops mem_wEn at once.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == DONE);
    bus.mem_wEn    = (state == WRITE);
  end

  // Lane extraction from the read word (little-endian lanes).
  always_comb begin
    rd_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: rd_byte = bus.mem_read_data[7:0];
      2'd1: rd_byte = bus.mem_read_data[15:8];
      2'd2: rd_byte = bus.mem_read_data[23:16];
      2'd3: rd_byte = bus.mem_read_data[31:24];
      default: rd_byte = 8'h00;
    endcase
    rd_half = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
  end

  always_comb begin
    load_ext = bus.mem_read_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h000000, rd_byte};
      3'b101:  load_ext = {16'h0000, rd_half};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  // Read-modify-write merge: only the addressed lane takes store data.
  always_comb begin
    merged = bus.mem_read_data;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // Captured request, merge word and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 16'h0000;
      wdata_q  <= 32'h0000_0000;
      merge_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        wen_q    <= bus.req_wEn;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr[15:0];
        wdata_q  <= bus.req_wdata;
        error_q  <= req_error;
        rdata_q  <= 32'h0000_0000;
      end else if (state == DATA) begin
        if (wen_q) begin
          merge_q <= merged;
        end else begin
          rdata_q <= load_ext;
        end
      end
    end
  end

  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_error  = error_q;
  assign bus.mem_address = {addr_q[15:2], 2'b00};
  // SW writes the captured word directly; SB/SH write the merged word.
  assign bus.mem_write_data = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a registered-read memory model
//   and a scoreboard of expected responses (data, error, latency in edges
//   counted from the acceptance edge).
module tb_load_store_unit;

  logic clk;
  logic rst;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read word memory (64 words is enough for the addresses used)
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (bus.mem_wEn) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    bus.mem_read_data <= mem[bus.mem_address[7:2]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int acc_count = 0;
  int resp_cnt = 0;
  int wr_count = 0;
  logic [15:0] last_wr_addr = 16'h0;
  logic [31:0] last_wr_data = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (bus.req_valid && bus.req_ready && !rst) begin
      acc_edge = edge_cnt;
      acc_count++;
    end
  end

  always @(negedge clk) begin
    if (bus.mem_wEn) begin
      wr_count++;
      last_wr_addr = bus.mem_address;
      last_wr_data = bus.mem_write_data;
    end
    if (bus.resp_valid) begin
      resp_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL resp_unexpected observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_error", {31'b0, bus.resp_error}, {31'b0, e.err});
        chk("resp_latency", edge_cnt - acc_edge, e.lat);
      end
    end
  end

  task automatic start_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic push,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
    bus.req_wEn    = wen;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    if (push) begin
      x.rdata = exp_rdata;
      x.err   = exp_err;
      x.lat   = exp_lat;
      sb.push_back(x);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    start_req(wen, f3, addr, wdata, 1'b1, exp_rdata, exp_err, exp_lat);
    drain("resp_timeout");
  endtask

  int wc;
  int rc;
  int k;
  int prev;
  int first_edge;
  int ready_cnt;

  initial begin
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_wEn    = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_error", {31'b0, bus.resp_error}, 32'd0);
    chk("rst_mem_wEn", {31'b0, bus.mem_wEn}, 32'd0);
    chk("rst_mem_address", {16'b0, bus.mem_address}, 32'd0);
    chk("rst_mem_write_data", bus.mem_write_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SW then LW
    wc = wr_count;
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    chk("sw_write_count", wr_count - wc, 32'd1);
    chk("sw_write_addr", {16'b0, last_wr_addr}, 32'h0000_0010);
    chk("sw_write_data", last_wr_data, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'hABCD_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

    // SB read-modify-write
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'h1111_1111, 32'h0, 1'b0, 1);
    do_req(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00AA, 32'h0, 1'b0, 3);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hAA11_1111, 1'b0, 2);
    do_req(1'b0, 3'b000, 32'h0000_0013, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
    do_req(1'b0, 3'b100, 32'h0000_0013, 32'h0, 32'h0000_00AA, 1'b0, 2);

    // SH read-modify-write
    do_req(1'b1, 3'b010, 32'h0000_0020, 32'h0000_0000, 32'h0, 1'b0, 1);
    do_req(1'b1, 3'b001, 32'h0000_0022, 32'h0000_8001, 32'h0, 1'b0, 3);
    do_req(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h8001_0000, 1'b0, 2);
    do_req(1'b0, 3'b001, 32'h0000_0022, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    do_req(1'b0, 3'b101, 32'h0000_0022, 32'h0, 32'h0000_8001, 1'b0, 2);

    // Error responses
    wc = wr_count;
    do_req(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1'b1, 0);
    do_req(1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 32'h0, 1'b1, 0);
    do_req(1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 0);
    do_req(1'b1, 3'b100, 32'h0000_0010, 32'h5555_5555, 32'h0, 1'b1, 0);
    chk("err_no_write", wr_count - wc, 32'd0);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hAA11_1111, 1'b0, 2);

    // Back-to-back LW with req_valid held high
    @(negedge clk);
    prev = acc_count;
    k = 0;
    first_edge = 0;
    ready_cnt = 0;
    bus.req_wEn    = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0010;
    bus.req_valid  = 1'b1;
    e.rdata = 32'hAA11_1111; e.err = 1'b0; e.lat = 2;
    sb.push_back(e);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (acc_count != prev) begin
        prev = acc_count;
        k++;
        if (k == 1) first_edge = acc_edge;
        if (k == 1) begin
          bus.req_addr = 32'h0000_0020;
          e.rdata = 32'h8001_0000; e.err = 1'b0; e.lat = 2;
          sb.push_back(e);
        end else if (k == 2) begin
          bus.req_addr = 32'h0000_0010;
          e.rdata = 32'hAA11_1111; e.err = 1'b0; e.lat = 2;
          sb.push_back(e);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (bus.req_ready) ready_cnt++;
    end
    bus.req_valid = 1'b0;
    drain("b2b_resp_timeout");
    chk("b2b_accepts", k, 32'd3);
    chk("b2b_spacing", acc_edge - first_edge, 32'd8);
    chk("b2b_ready_cycles", ready_cnt, 32'd3);

    // Reset during READ of SB
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 1);
    wc = wr_count;
    rc = resp_cnt;
    start_req(1'b1, 3'b000, 32'h0000_0010, 32'h0000_00AA, 1'b0, 32'h0, 1'b0, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_read_mem_wEn", {31'b0, bus.mem_wEn}, 32'd0);
    chk("rst_read_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_read_ready_after", {31'b0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_read_no_resp", resp_cnt - rc, 32'd0);
    chk("rst_read_no_write", wr_count - wc, 32'd0);
    chk("rst_read_mem", mem[4], 32'h1234_5678);

    // Reset during WRITE of SB, before its edge
    wc = wr_count;
    rc = resp_cnt;
    start_req(1'b1, 3'b000, 32'h0000_0011, 32'h0000_0055, 1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("wr_phase_mem_wEn", {31'b0, bus.mem_wEn}, 32'd1);
    chk("wr_phase_addr", {16'b0, bus.mem_address}, 32'h0000_0010);
    chk("wr_phase_data", bus.mem_write_data, 32'h1234_5578);
    rst = 1'b1;
    #1 chk("rst_write_mem_wEn", {31'b0, bus.mem_wEn}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_write_ready_after", {31'b0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_write_no_resp", resp_cnt - rc, 32'd0);
    chk("rst_write_no_write", wr_count - wc, 32'd0);
    chk("rst_write_mem", mem[4], 32'h1234_5678);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
